// File: rtl/sau_link_pkg.sv
// Shared types and line-level constants for the SAU serial byte link.
package sau_link_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} link_state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sau_link_fifo.sv
// Synchronous TX byte FIFO; pointers carry one wrap bit so full/empty need no counter.
module sau_link_fifo #(
   parameter int DW       = 8,
   parameter int TX_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] wdata,
   input  logic          pop,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(TX_DEPTH);

   logic [DW-1:0] mem [TX_DEPTH];
   logic [AW:0]   wptr, rptr;
   logic          do_push, do_pop;

   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty   = (wptr == rptr);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else if (flush) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/sau_link_slave.sv
// Device-side SAU link endpoint: RX deframer, TX serialiser fed from a small FIFO.
// Optional parity bit enabled with macro SAU_LINK_PARITY_EN.
//
// state | meaning
// IDLE  | line idle, waiting for start bit (RX) or FIFO data (TX)
// START | TX driving start bit
// DATA  | shifting DW data bits, MSB first
// PAR   | even parity bit (SAU_LINK_PARITY_EN only)
// STOP  | stop bit; TX may chain straight into the next START
module sau_link_slave
   import sau_link_pkg::*;
#(
   parameter int TX_DEPTH = 4,
   parameter int DW       = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          sin,
   output logic          sout,
   output logic [DW-1:0] rx_data,
   output logic          rx_valid,
   output logic          rx_err,
   input  logic [DW-1:0] tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic          tx_idle
);
   localparam int             CW       = cnt_w(DW);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);

   link_state_t   rx_state, tx_state;
   logic [CW-1:0] rx_cnt, tx_cnt;
   logic [DW-1:0] rx_shift, tx_shift;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_full, fifo_empty, fifo_push, tx_pop;
`ifdef SAU_LINK_PARITY_EN
   logic          rx_par_ok, tx_par;
`endif

   assign tx_ready  = !fifo_full;
   assign fifo_push = en && tx_valid && !fifo_full;
   assign tx_pop    = en && !fifo_empty && (tx_state == IDLE || tx_state == STOP);
   assign tx_idle   = fifo_empty && (tx_state == IDLE);

   sau_link_fifo #(.DW(DW), .TX_DEPTH(TX_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (!en),
      .push  (fifo_push),
      .wdata (tx_data),
      .pop   (tx_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_shift <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
`ifdef SAU_LINK_PARITY_EN
         rx_par_ok <= 1'b0;
`endif
      end else begin
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         if (!en) begin
            rx_state <= IDLE;
         end else begin
            case (rx_state)
               IDLE: if (sin == START_BIT) begin
                  rx_state <= DATA;
                  rx_cnt   <= '0;
               end
               DATA: begin
                  rx_shift <= {rx_shift[DW-2:0], sin};
                  if (rx_cnt == CNT_LAST) begin
`ifdef SAU_LINK_PARITY_EN
                     rx_state <= PAR;
`else
                     rx_state <= STOP;
`endif
                  end else begin
                     rx_cnt <= rx_cnt + 1'b1;
                  end
               end
`ifdef SAU_LINK_PARITY_EN
               PAR: begin
                  rx_par_ok <= (sin == ^rx_shift);
                  rx_state  <= STOP;
               end
`endif
               STOP: begin
`ifdef SAU_LINK_PARITY_EN
                  if (sin == STOP_BIT && rx_par_ok) begin
`else
                  if (sin == STOP_BIT) begin
`endif
                     rx_data  <= rx_shift;
                     rx_valid <= 1'b1;
                  end else begin
                     rx_err <= 1'b1;
                  end
                  rx_state <= IDLE;
               end
               default: rx_state <= IDLE;
            endcase
         end
      end
   end

   // tx_cnt counts down from DW-1; the frame leaves DATA on terminal count 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_shift <= '0;
         sout     <= IDLE_LVL;
`ifdef SAU_LINK_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else if (!en) begin
         tx_state <= IDLE;
         sout     <= IDLE_LVL;
      end else begin
         case (tx_state)
            IDLE, STOP: begin
               if (tx_pop) begin
                  tx_shift <= fifo_rdata;
`ifdef SAU_LINK_PARITY_EN
                  tx_par   <= ^fifo_rdata;
`endif
                  sout     <= START_BIT;
                  tx_state <= START;
               end else begin
                  sout     <= IDLE_LVL;
                  tx_state <= IDLE;
               end
            end
            START: begin
               sout     <= tx_shift[DW-1];
               tx_shift <= tx_shift << 1;
               tx_cnt   <= CNT_LAST;
               tx_state <= DATA;
            end
            DATA: begin
               if (tx_cnt == '0) begin
`ifdef SAU_LINK_PARITY_EN
                  sout     <= tx_par;
                  tx_state <= PAR;
`else
                  sout     <= STOP_BIT;
                  tx_state <= STOP;
`endif
               end else begin
                  tx_cnt   <= tx_cnt - 1'b1;
                  sout     <= tx_shift[DW-1];
                  tx_shift <= tx_shift << 1;
               end
            end
            PAR: begin
               sout     <= STOP_BIT;
               tx_state <= STOP;
            end
            default: begin
               sout     <= IDLE_LVL;
               tx_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sau_link_slave.sv
// Directed bench for sau_link_slave; frames built bit by bit from hand-known byte values.
module tb_sau_link_slave;
`ifdef SAU_LINK_PARITY_EN
   localparam int FL = 11;
`else
   localparam int FL = 10;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       sin_drv = 1'b1;
   logic       lb = 1'b0;
   logic       sin_w;
   logic       sout;
   logic [7:0] rx_data;
   logic       rx_valid, rx_err;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_idle;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] rx_q[$];
   int         err_cnt = 0;

   assign sin_w = lb ? sout : sin_drv;

   sau_link_slave #(.TX_DEPTH(4), .DW(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sin      (sin_w),
      .sout     (sout),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_err   (rx_err),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_idle  (tx_idle)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (rx_err)   err_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // bit FL-1 goes on the wire first
   function automatic logic [FL-1:0] frame(input logic [7:0] b, input logic stop, input logic par_flip);
`ifdef SAU_LINK_PARITY_EN
      return {1'b0, b, (^b) ^ par_flip, stop};
`else
      return {1'b0, b, stop ^ par_flip ^ par_flip};
`endif
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
      logic [FL-1:0] f;
      f = frame(b, stop, par_flip);
      for (int i = FL - 1; i >= 0; i--) begin
         sin_drv = f[i];
         tick();
      end
      sin_drv = 1'b1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      int t;
      t = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (!tx_ready && t < 200) begin
         tick();
         t++;
      end
      n_tests++;
      if (!tx_ready) begin
         n_fail++;
         $display("FAIL push_wait: tx_ready stuck at %b for byte %h", tx_ready, b);
      end
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic wait_tx_idle(input string name);
      int t;
      t = 0;
      while (!tx_idle && t < 2000) begin
         tick();
         t++;
      end
      n_tests++;
      if (tx_idle !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: tx_idle is %b after %0d cycles, need 1", name, tx_idle, t);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      n_tests += 6;
      if (sout !== 1'b1)     begin n_fail++; $display("FAIL reset_sout: got %b need 1", sout); end
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h need 00", rx_data); end
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b need 0", rx_valid); end
      if (rx_err !== 1'b0)   begin n_fail++; $display("FAIL reset_rx_err: got %b need 0", rx_err); end
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b need 1", tx_ready); end
      if (tx_idle !== 1'b1)  begin n_fail++; $display("FAIL reset_tx_idle: got %b need 1", tx_idle); end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_rx_single();
      int e0;
      e0 = err_cnt;
      send_frame(8'h31, 1'b1, 1'b0);
      n_tests += 3;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_single_valid: got %b need 1", rx_valid); end
      if (rx_data !== 8'h31) begin n_fail++; $display("FAIL rx_single_data: got %h need 31", rx_data); end
      if (rx_err !== 1'b0)   begin n_fail++; $display("FAIL rx_single_err: got %b need 0", rx_err); end
      tick();
      n_tests += 2;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_single_strobe: got %b need 0", rx_valid); end
      if (err_cnt !== e0)    begin n_fail++; $display("FAIL rx_single_errcnt: got %0d need %0d", err_cnt - e0, 0); end
   endtask

   task automatic test_rx_framing();
      int q0;
      q0 = rx_q.size();
      send_frame(8'h30, 1'b0, 1'b0);
      n_tests += 3;
      if (rx_err !== 1'b1)   begin n_fail++; $display("FAIL rx_frame_err: got %b need 1", rx_err); end
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_frame_valid: got %b need 0", rx_valid); end
      if (rx_data !== 8'h31) begin n_fail++; $display("FAIL rx_frame_hold: got %h need 31", rx_data); end
      tick();
      send_frame(8'h32, 1'b1, 1'b0);
      n_tests += 3;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_resync_valid: got %b need 1", rx_valid); end
      if (rx_data !== 8'h32) begin n_fail++; $display("FAIL rx_resync_data: got %h need 32", rx_data); end
      tick();
      if (rx_q.size() !== q0 + 1) begin n_fail++; $display("FAIL rx_frame_count: got %0d need 1", rx_q.size() - q0); end
   endtask

`ifdef SAU_LINK_PARITY_EN
   task automatic test_parity();
      send_frame(8'h07, 1'b1, 1'b1);
      n_tests += 2;
      if (rx_err !== 1'b1)   begin n_fail++; $display("FAIL par_bad_err: got %b need 1", rx_err); end
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL par_bad_valid: got %b need 0", rx_valid); end
      tick();
      send_frame(8'h07, 1'b1, 1'b0);
      n_tests += 3;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL par_ok_valid: got %b need 1", rx_valid); end
      if (rx_err !== 1'b0)   begin n_fail++; $display("FAIL par_ok_err: got %b need 0", rx_err); end
      if (rx_data !== 8'h07) begin n_fail++; $display("FAIL par_ok_data: got %h need 07", rx_data); end
      tick();
   endtask
`endif

   task automatic test_tx_burst();
      logic [7:0]    bytes [5];
      logic          cap [1 + 5*FL];
      logic [FL-1:0] f;
      int            bad;
      bytes = '{8'h11, 8'h02, 8'h30, 8'h31, 8'h32};
      fork
         begin
            tx_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
               tx_data = bytes[k];
               tick();
            end
            tx_valid = 1'b0;
            n_tests++;
            if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL tx_full_ready: got %b need 0", tx_ready); end
         end
         begin
            for (int i = 0; i < 1 + 5*FL; i++) begin
               tick();
               cap[i] = sout;
            end
         end
      join
      n_tests++;
      if (cap[0] !== 1'b1) begin n_fail++; $display("FAIL tx_pre_idle: got %b need 1", cap[0]); end
      for (int k = 0; k < 5; k++) begin
         f   = frame(bytes[k], 1'b1, 1'b0);
         bad = 0;
         for (int j = 0; j < FL; j++)
            if (cap[1 + k*FL + j] !== f[FL-1-j]) bad++;
         n_tests++;
         if (bad != 0) begin n_fail++; $display("FAIL tx_frame%0d: %0d bits differ for byte %h", k, bad, bytes[k]); end
      end
      n_tests++;
      if (tx_idle !== 1'b0) begin n_fail++; $display("FAIL tx_idle_in_stop: got %b need 0", tx_idle); end
      tick();
      n_tests += 2;
      if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL tx_idle_end: got %b need 1", tx_idle); end
      if (sout !== 1'b1)    begin n_fail++; $display("FAIL tx_sout_end: got %b need 1", sout); end
      repeat (2) tick();
   endtask

   task automatic test_loopback();
      logic [7:0] exp_b;
      int         q0, e0, bad;
      q0 = rx_q.size();
      e0 = err_cnt;
      lb = 1'b1;
      for (int k = 0; k < 13; k++) begin
         exp_b = 8'h30 + 8'(k % 5);
         push_byte(exp_b);
      end
      wait_tx_idle("loop_idle");
      repeat (3) tick();
      n_tests += 2;
      if (rx_q.size() !== q0 + 13) begin n_fail++; $display("FAIL loop_count: got %0d need 13", rx_q.size() - q0); end
      if (err_cnt !== e0)          begin n_fail++; $display("FAIL loop_err: got %0d need 0", err_cnt - e0); end
      bad = 0;
      for (int k = 0; k < 13 && q0 + k < rx_q.size(); k++) begin
         exp_b = 8'h30 + 8'(k % 5);
         if (rx_q[q0 + k] !== exp_b) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL loop_data: %0d bytes differ", bad); end
      lb = 1'b0;
      tick();
   endtask

   task automatic test_abort();
      logic [FL-1:0] f;
      int            q0, e0;
      q0 = rx_q.size();
      e0 = err_cnt;
      push_byte(8'hC3);
      push_byte(8'h3C);
      f = frame(8'h5A, 1'b1, 1'b0);
      for (int i = FL - 1; i > FL - 6; i--) begin
         sin_drv = f[i];
         tick();
      end
      en = 1'b0;
      sin_drv = f[FL-6];
      tick();
      n_tests += 3;
      if (sout !== 1'b1)     begin n_fail++; $display("FAIL abort_sout: got %b need 1", sout); end
      if (tx_idle !== 1'b1)  begin n_fail++; $display("FAIL abort_flush: tx_idle %b need 1", tx_idle); end
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b need 1", tx_ready); end
      for (int i = FL - 7; i >= 0; i--) begin
         sin_drv = f[i];
         tick();
      end
      sin_drv = 1'b1;
      tick();
      en = 1'b1;
      repeat (3) tick();
      n_tests += 4;
      if (sout !== 1'b1)           begin n_fail++; $display("FAIL abort_resume_sout: got %b need 1", sout); end
      if (tx_idle !== 1'b1)        begin n_fail++; $display("FAIL abort_resume_idle: got %b need 1", tx_idle); end
      if (rx_q.size() !== q0)      begin n_fail++; $display("FAIL abort_rx_valid: got %0d strobes need 0", rx_q.size() - q0); end
      if (err_cnt !== e0)          begin n_fail++; $display("FAIL abort_rx_err: got %0d strobes need 0", err_cnt - e0); end
      lb = 1'b1;
      push_byte(8'hA5);
      wait_tx_idle("abort_a5_idle");
      repeat (3) tick();
      n_tests += 2;
      if (rx_q.size() !== q0 + 1) begin
         n_fail++;
         $display("FAIL abort_a5_count: got %0d need 1", rx_q.size() - q0);
      end else if (rx_q[q0] !== 8'hA5) begin
         n_fail++;
         $display("FAIL abort_a5_data: got %h need a5", rx_q[q0]);
      end
      if (err_cnt !== e0) begin n_fail++; $display("FAIL abort_a5_err: got %0d need 0", err_cnt - e0); end
      lb = 1'b0;
      tick();
   endtask

   task automatic test_async_reset();
      push_byte(8'h81);
      push_byte(8'h7E);
      repeat (3) tick();
      n_tests++;
      if (tx_idle !== 1'b0) begin n_fail++; $display("FAIL arst_busy: tx_idle %b need 0", tx_idle); end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests += 4;
      if (sout !== 1'b1)     begin n_fail++; $display("FAIL arst_sout: got %b need 1", sout); end
      if (tx_idle !== 1'b1)  begin n_fail++; $display("FAIL arst_idle: got %b need 1", tx_idle); end
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b need 1", tx_ready); end
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL arst_rx_data: got %h need 00", rx_data); end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      n_tests++;
      if (sout !== 1'b1) begin n_fail++; $display("FAIL arst_after_sout: got %b need 1", sout); end
   endtask

   initial begin
      test_reset();
      test_rx_single();
      test_rx_framing();
`ifdef SAU_LINK_PARITY_EN
      test_parity();
`endif
      test_tx_burst();
      test_loopback();
      test_abort();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
